// File: rtl/shift_add_sequencer.sv
// Control and accumulate stage of the sequential shift-and-add multiplier.
// One iteration per clock for WIDTH cycles, then a one-cycle done pulse with the registered product.
module shift_add_sequencer #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [WIDTH-1:0]   multiplicand,
   input  logic [WIDTH-1:0]   multiplier,
   output logic               busy,
   output logic               done,
   output logic               shift,
   output logic               add_shift,
   output logic [2*WIDTH-1:0] partial_sum,
   output logic [2*WIDTH-1:0] product
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             state, state_next;
   logic [2*WIDTH-1:0] p, p_next, p_step, product_next;
   logic [WIDTH-1:0]   m, m_next;
   logic [CW-1:0]      count, count_next;
   logic [WIDTH:0]     sum;

   // One iteration: add M into the upper half when the current Q bit is set,
   // then shift right with the adder carry entering the MSB.
   always_comb begin
      sum    = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, m} : '0);
      p_step = {sum, p[WIDTH-1:1]};
   end

   always_comb begin
      state_next   = state;
      p_next       = p;
      m_next       = m;
      count_next   = count;
      product_next = product;
      busy         = 1'b0;
      done         = 1'b0;
      shift        = 1'b0;
      add_shift    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               m_next     = multiplicand;
               p_next     = {{WIDTH{1'b0}}, multiplier};
               count_next = '0;
               state_next = RUN;
            end
         end
         RUN: begin
            busy       = 1'b1;
            add_shift  = p[0];
            shift      = ~p[0];
            p_next     = p_step;
            count_next = count + 1'b1;
            if (count == CW'(WIDTH - 1)) begin
               product_next = p_step;
               state_next   = DONE;
            end
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         p       <= '0;
         m       <= '0;
         count   <= '0;
         product <= '0;
      end else begin
         state   <= state_next;
         p       <= p_next;
         m       <= m_next;
         count   <= count_next;
         product <= product_next;
      end
   end

   assign partial_sum = p;

endmodule

// File: tb/tb_shift_add_sequencer.sv
// Bench for shift_add_sequencer: directed and random multiplications against an arithmetic model
// of the product, the per-cycle strobes and the partial product register.
module tb_shift_add_sequencer;

   localparam int W  = 8;
   localparam int PW = 2 * W;

   logic          clk = 1'b0;
   logic          reset, start;
   logic [W-1:0]  mc, mp;
   logic          busy, done, shift, add_shift;
   logic [PW-1:0] partial_sum, product;

   int            checks = 0;
   int            errors = 0;
   logic [PW-1:0] last_product, last_p;

   shift_add_sequencer #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .start(start),
      .multiplicand(mc), .multiplier(mp),
      .busy(busy), .done(done), .shift(shift), .add_shift(add_shift),
      .partial_sum(partial_sum), .product(product)
   );

   always #5 clk = ~clk;

   // After i iterations, P holds M*(low i bits of Q) aligned at bit W-i, above the unconsumed Q bits.
   function automatic logic [PW-1:0] model_p(input logic [W-1:0] m, input logic [W-1:0] q, input int i);
      longint unsigned mm, qq, lo, acc;
      mm  = m;
      qq  = q;
      lo  = qq & ((64'd1 << i) - 64'd1);
      acc = (mm * lo) << (W - i);
      return PW'(acc | (qq >> i));
   endfunction

   function automatic logic [PW-1:0] model_product(input logic [W-1:0] m, input logic [W-1:0] q);
      longint unsigned mm, qq;
      mm = m;
      qq = q;
      return PW'(mm * qq);
   endfunction

   task automatic do_mult(input logic [W-1:0] m, input logic [W-1:0] q);
      logic [PW-1:0] exp_prod;
      exp_prod = model_product(m, q);
      @(negedge clk);
      checks++;
      if ({busy, done, shift, add_shift} !== 4'b0000) begin
         errors++; $display("FAIL idle_flags got %b exp 0000", {busy, done, shift, add_shift});
      end
      checks++;
      if (product !== last_product) begin
         errors++; $display("FAIL idle_product got %h exp %h", product, last_product);
      end
      checks++;
      if (partial_sum !== last_p) begin
         errors++; $display("FAIL idle_psum got %h exp %h", partial_sum, last_p);
      end
      start = 1'b1; mc = m; mp = q;
      @(posedge clk);
      #1 start = 1'b0;
      mc = W'($urandom); mp = W'($urandom);
      for (int i = 0; i < W; i++) begin
         @(negedge clk);
         checks++;
         if ({busy, done} !== 2'b10) begin
            errors++; $display("FAIL run_busy iter %0d got %b exp 10", i, {busy, done});
         end
         checks++;
         if ({add_shift, shift} !== {q[i], ~q[i]}) begin
            errors++; $display("FAIL run_strobe iter %0d got %b exp %b", i, {add_shift, shift}, {q[i], ~q[i]});
         end
         checks++;
         if (partial_sum !== model_p(m, q, i)) begin
            errors++; $display("FAIL run_psum iter %0d got %h exp %h", i, partial_sum, model_p(m, q, i));
         end
      end
      @(negedge clk);
      checks++;
      if ({busy, done, shift, add_shift} !== 4'b0100) begin
         errors++; $display("FAIL done_flags got %b exp 0100", {busy, done, shift, add_shift});
      end
      checks++;
      if (product !== exp_prod) begin
         errors++; $display("FAIL done_product m=%h q=%h got %h exp %h", m, q, product, exp_prod);
      end
      last_product = exp_prod;
      last_p       = exp_prod;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; mc = '0; mp = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({busy, done, shift, add_shift} !== 4'b0000) begin
         errors++; $display("FAIL reset_flags got %b exp 0000", {busy, done, shift, add_shift});
      end
      checks++;
      if (product !== '0) begin
         errors++; $display("FAIL reset_product got %h exp 0", product);
      end
      checks++;
      if (partial_sum !== '0) begin
         errors++; $display("FAIL reset_psum got %h exp 0", partial_sum);
      end
      reset = 1'b0;
      last_product = '0;
      last_p       = '0;
   endtask

   task automatic test_basic();
      do_mult(8'd13, 8'd11);
      checks++;
      if (product !== 16'h008F) begin
         errors++; $display("FAIL basic_const got %h exp 008f", product);
      end
   endtask

   task automatic test_carry();
      do_mult(8'hFF, 8'hFF);
      checks++;
      if (product !== 16'hFE01) begin
         errors++; $display("FAIL carry_const got %h exp fe01", product);
      end
   endtask

   task automatic test_strobe_pattern();
      do_mult(8'h03, 8'hA5);
      checks++;
      if (product !== 16'h01EF) begin
         errors++; $display("FAIL pattern_const got %h exp 01ef", product);
      end
   endtask

   task automatic test_zero_pass();
      do_mult(8'h37, 8'h00);
      checks++;
      if (product !== 16'h0000) begin
         errors++; $display("FAIL zero_const got %h exp 0000", product);
      end
      do_mult(8'h01, 8'h80);
      checks++;
      if (product !== 16'h0080) begin
         errors++; $display("FAIL pass_const got %h exp 0080", product);
      end
   endtask

   task automatic test_reset_mid_op();
      logic saw_done;
      @(negedge clk);
      start = 1'b1; mc = 8'd9; mp = 8'd9;
      @(posedge clk);
      #1 start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if (busy !== 1'b1) begin
            errors++; $display("FAIL abort_busy iter %0d got %b exp 1", i, busy);
         end
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checks++;
      if ({busy, done} !== 2'b00) begin
         errors++; $display("FAIL abort_flags got %b exp 00", {busy, done});
      end
      checks++;
      if (product !== '0) begin
         errors++; $display("FAIL abort_product got %h exp 0", product);
      end
      checks++;
      if (partial_sum !== '0) begin
         errors++; $display("FAIL abort_psum got %h exp 0", partial_sum);
      end
      saw_done = 1'b0;
      repeat (15) begin
         @(negedge clk);
         if (done !== 1'b0) saw_done = 1'b1;
      end
      checks++;
      if (saw_done !== 1'b0) begin
         errors++; $display("FAIL abort_no_done got %b exp 0", saw_done);
      end
      last_product = '0;
      last_p       = '0;
   endtask

   task automatic test_start_held();
      int n;
      @(negedge clk);
      start = 1'b1; mc = 8'd6; mp = 8'd7;
      @(posedge clk);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (done !== 1'b1 && n < 30);
      checks++;
      if (n !== W + 1) begin
         errors++; $display("FAIL held_latency1 got %0d exp %0d", n, W + 1);
      end
      checks++;
      if ({busy, product} !== {1'b0, 16'd42}) begin
         errors++; $display("FAIL held_done1 got busy=%b prod=%h exp busy=0 prod=002a", busy, product);
      end
      @(negedge clk);
      checks++;
      if ({busy, done} !== 2'b00) begin
         errors++; $display("FAIL held_idle got %b exp 00", {busy, done});
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin
         errors++; $display("FAIL held_restart got %b exp 1", busy);
      end
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (done !== 1'b1 && n < 30);
      start = 1'b0;
      checks++;
      if (n !== W) begin
         errors++; $display("FAIL held_latency2 got %0d exp %0d", n, W);
      end
      checks++;
      if (product !== 16'd42) begin
         errors++; $display("FAIL held_done2 got %h exp 002a", product);
      end
      last_product = 16'd42;
      last_p       = 16'd42;
   endtask

   task automatic test_random();
      for (int k = 0; k < 20; k++) begin
         do_mult(W'($urandom), W'($urandom_range(0, 255)));
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_carry();
      test_strobe_pattern();
      test_zero_pass();
      test_reset_mid_op();
      test_start_held();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
